debug_ring_link: RTL and testbench

Elastic inter-segment link for the two-channel debug ring. It connects the two extension outputs of one expanded ring segment to the two extension inputs of the next segment, or of a ring turnaround. Each channel has an independent flit FIFO, which breaks the long ready/valid combinational path between segments. An optional store-and-forward mode releases a packet only once it is complete.

---
 rtl/debug_ring_link.sv | 95 +++++++++
 tb/tb_debug_ring_link.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ring_link.sv
// Two-channel elastic link between debug ring segments: one flit FIFO per channel,
// with optional store-and-forward release of complete packets.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module debug_ring_link
  import dii_package::*;
#(
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned STORE_FWD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  dii_flit [1:0] link_in,
  output logic    [1:0] link_in_ready,
  output dii_flit [1:0] link_out,
  input  logic    [1:0] link_out_ready
);

  localparam int unsigned AW   = $clog2(BUFFER_SIZE);
  localparam logic [AW:0] FULL = (AW + 1)'(BUFFER_SIZE);

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [16:0]   r_mem [BUFFER_SIZE];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_pkt;
    logic          r_stream;

    logic          w_in_ready;
    logic          w_release;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_push_last;
    logic          w_pop_last;
    logic [16:0]   w_head;

    always_comb begin
      w_head      = r_mem[r_rptr];
      w_in_ready  = !rst && (r_cnt != FULL);
      // A full FIFO releases a partial packet so packets longer than the buffer cannot deadlock.
      w_release   = (STORE_FWD == 0) || (r_pkt != '0) || (r_cnt == FULL) || r_stream;
      w_valid     = !rst && (r_cnt != '0) && w_release;
      w_push      = link_in[ch].valid && w_in_ready;
      w_pop       = w_valid && link_out_ready[ch];
      w_push_last = w_push && link_in[ch].last;
      w_pop_last  = w_pop && w_head[16];
    end

    assign link_in_ready[ch] = w_in_ready;
    assign link_out[ch]      = {w_valid, w_head};

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wptr] <= {link_in[ch].last, link_in[ch].data};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_cnt    <= '0;
        r_pkt    <= '0;
        r_stream <= 1'b0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr   <= r_rptr + 1'b1;
          r_stream <= !w_head[16];
        end
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
          r_cnt <= r_cnt - 1'b1;
        end
        if (w_push_last && !w_pop_last) begin
          r_pkt <= r_pkt + 1'b1;
        end else if (!w_push_last && w_pop_last) begin
          r_pkt <= r_pkt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_ring_link.sv
// Bench for debug_ring_link: a cut-through and a store-and-forward instance (depth 4),
// per-stream scoreboards plus a table of per-cycle ready/valid/head expectations.
module tb_debug_ring_link;
  import dii_package::*;

  logic          clk;
  logic          rst;
  dii_flit [1:0] ct_in, ct_out, sf_in, sf_out;
  logic    [1:0] ct_in_rdy, ct_out_rdy, sf_in_rdy, sf_out_rdy;

  debug_ring_link #(.BUFFER_SIZE(4), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst(rst), .link_in(ct_in), .link_in_ready(ct_in_rdy),
    .link_out(ct_out), .link_out_ready(ct_out_rdy));

  debug_ring_link #(.BUFFER_SIZE(4), .STORE_FWD(1)) u_sf (
    .clk(clk), .rst(rst), .link_in(sf_in), .link_in_ready(sf_in_rdy),
    .link_out(sf_out), .link_out_ready(sf_out_rdy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  logic [16:0] sb [4][$];

  typedef struct {
    int          sel;
    logic        iv;
    logic        il;
    logic [15:0] id;
    logic        ordy;
    logic        exp_irdy;
    logic        exp_ov;
    logic [16:0] exp_head;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // stream s: 0/1 = cut-through ch0/ch1, 2/3 = store-and-forward ch0/ch1
  function automatic dii_flit in_f(int s);
    case (s)
      0: return ct_in[0];
      1: return ct_in[1];
      2: return sf_in[0];
      default: return sf_in[1];
    endcase
  endfunction

  function automatic dii_flit out_f(int s);
    case (s)
      0: return ct_out[0];
      1: return ct_out[1];
      2: return sf_out[0];
      default: return sf_out[1];
    endcase
  endfunction

  function automatic logic irdy_f(int s);
    case (s)
      0: return ct_in_rdy[0];
      1: return ct_in_rdy[1];
      2: return sf_in_rdy[0];
      default: return sf_in_rdy[1];
    endcase
  endfunction

  function automatic logic ordy_f(int s);
    case (s)
      0: return ct_out_rdy[0];
      1: return ct_out_rdy[1];
      2: return sf_out_rdy[0];
      default: return sf_out_rdy[1];
    endcase
  endfunction

  task automatic set_in(input int s, input logic v, input logic l, input logic [15:0] d);
    dii_flit f;
    f = '{valid: v, last: l, data: d};
    case (s)
      0: ct_in[0] = f;
      1: ct_in[1] = f;
      2: sf_in[0] = f;
      default: sf_in[1] = f;
    endcase
  endtask

  task automatic set_ordy(input int s, input logic r);
    case (s)
      0: ct_out_rdy[0] = r;
      1: ct_out_rdy[1] = r;
      2: sf_out_rdy[0] = r;
      default: sf_out_rdy[1] = r;
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 4; s++) begin
      set_in(s, 1'b0, 1'b0, 16'h0);
      set_ordy(s, 1'b1);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_v(int sel, logic iv, logic il, logic [15:0] id, logic ordy,
                                logic eir, logic eov, logic [16:0] eh);
    vec_t v;
    v = '{sel: sel, iv: iv, il: il, id: id, ordy: ordy, exp_irdy: eir, exp_ov: eov, exp_head: eh};
    vt.push_back(v);
  endfunction

  // Scoreboard: compare every output handshake against the oldest accepted flit.
  dii_flit m_fi, m_fo;
  logic [16:0] m_exp;
  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      if (rst) begin
        sb[s].delete();
      end else begin
        m_fi = in_f(s);
        m_fo = out_f(s);
        if (m_fo.valid && ordy_f(s)) begin
          if (sb[s].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected_s%0d: got flit 0x%0h, required no output at %0t",
                     s, {m_fo.last, m_fo.data}, $time);
          end else begin
            m_exp = sb[s].pop_front();
            chk($sformatf("sb_flit_s%0d", s), 32'({m_fo.last, m_fo.data}), 32'(m_exp));
          end
        end
        if (m_fi.valid && irdy_f(s)) sb[s].push_back({m_fi.last, m_fi.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int pending;
    idle_all();
    pending = 0;
    for (int c = 0; c < 50; c++) begin
      pending = 0;
      for (int s = 0; s < 4; s++) pending += sb[s].size();
      if (pending == 0) break;
      nxt();
    end
    chk("drain_pending", 32'(pending), 32'd0);
  endtask

  initial begin
    int acc0;
    logic r0;
    dii_flit f;

    // backpressure fill on cut-through ch0
    add_v(0, 1, 0, 16'hB000, 0, 1, 0, 17'h0);
    add_v(0, 1, 0, 16'hB001, 0, 1, 1, {1'b0, 16'hB000});
    add_v(0, 1, 0, 16'hB002, 0, 1, 1, {1'b0, 16'hB000});
    add_v(0, 1, 0, 16'hB003, 0, 1, 1, {1'b0, 16'hB000});
    add_v(0, 1, 1, 16'hB004, 0, 0, 1, {1'b0, 16'hB000});
    add_v(0, 1, 1, 16'hB004, 0, 0, 1, {1'b0, 16'hB000});
    add_v(0, 1, 1, 16'hB004, 1, 0, 1, {1'b0, 16'hB000});
    add_v(0, 1, 1, 16'hB004, 1, 1, 1, {1'b0, 16'hB001});
    add_v(0, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'hB002});
    add_v(0, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'hB003});
    add_v(0, 0, 0, 16'h0,    1, 1, 1, {1'b1, 16'hB004});
    add_v(0, 0, 0, 16'h0,    1, 1, 0, 17'h0);
    // store-and-forward 3-flit packet with gaps on sf ch0
    add_v(2, 1, 0, 16'hA001, 1, 1, 0, 17'h0);
    add_v(2, 0, 0, 16'h0,    1, 1, 0, 17'h0);
    add_v(2, 1, 0, 16'hA002, 1, 1, 0, 17'h0);
    add_v(2, 0, 0, 16'h0,    1, 1, 0, 17'h0);
    add_v(2, 1, 1, 16'hA003, 1, 1, 0, 17'h0);
    add_v(2, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'hA001});
    add_v(2, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'hA002});
    add_v(2, 0, 0, 16'h0,    1, 1, 1, {1'b1, 16'hA003});
    add_v(2, 0, 0, 16'h0,    1, 1, 0, 17'h0);
    // 6-flit packet escapes through a full FIFO on sf ch1, then a normal packet is held again
    add_v(3, 1, 0, 16'h5000, 1, 1, 0, 17'h0);
    add_v(3, 1, 0, 16'h5001, 1, 1, 0, 17'h0);
    add_v(3, 1, 0, 16'h5002, 1, 1, 0, 17'h0);
    add_v(3, 1, 0, 16'h5003, 1, 1, 0, 17'h0);
    add_v(3, 1, 0, 16'h5004, 1, 0, 1, {1'b0, 16'h5000});
    add_v(3, 1, 0, 16'h5004, 1, 1, 1, {1'b0, 16'h5001});
    add_v(3, 1, 1, 16'h5005, 1, 1, 1, {1'b0, 16'h5002});
    add_v(3, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'h5003});
    add_v(3, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'h5004});
    add_v(3, 0, 0, 16'h0,    1, 1, 1, {1'b1, 16'h5005});
    add_v(3, 1, 0, 16'hC000, 1, 1, 0, 17'h0);
    add_v(3, 0, 0, 16'h0,    1, 1, 0, 17'h0);
    add_v(3, 1, 1, 16'hC001, 1, 1, 0, 17'h0);
    add_v(3, 0, 0, 16'h0,    1, 1, 1, {1'b0, 16'hC000});
    add_v(3, 0, 0, 16'h0,    1, 1, 1, {1'b1, 16'hC001});
    add_v(3, 0, 0, 16'h0,    1, 1, 0, 17'h0);

    // reset held with valid inputs
    rst = 1'b1;
    idle_all();
    for (int s = 0; s < 4; s++) set_in(s, 1'b1, 1'b0, 16'h0EEE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ct_in_ready", 32'(ct_in_rdy), 32'd0);
      chk("rst_sf_in_ready", 32'(sf_in_rdy), 32'd0);
      chk("rst_ct_out_valid", 32'({ct_out[1].valid, ct_out[0].valid}), 32'd0);
      chk("rst_sf_out_valid", 32'({sf_out[1].valid, sf_out[0].valid}), 32'd0);
      nxt();
    end
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    chk("post_rst_ct_in_ready", 32'(ct_in_rdy), 32'd3);
    chk("post_rst_sf_in_ready", 32'(sf_in_rdy), 32'd3);
    chk("post_rst_ct_out_valid", 32'({ct_out[1].valid, ct_out[0].valid}), 32'd0);
    chk("post_rst_sf_out_valid", 32'({sf_out[1].valid, sf_out[0].valid}), 32'd0);
    nxt();

    // back-to-back streaming, one-cycle latency, no bubbles
    for (int k = 0; k <= 9; k++) begin
      idle_all();
      if (k < 8) set_in(0, 1'b1, (k == 7), 16'(16'h1000 + k));
      @(negedge clk);
      if (k < 8) chk($sformatf("stream_in_ready_%0d", k), 32'(ct_in_rdy[0]), 32'd1);
      chk($sformatf("stream_out_valid_%0d", k), 32'(ct_out[0].valid), 32'((k != 0) && (k != 9)));
      if (k != 0 && k != 9)
        chk($sformatf("stream_head_%0d", k), 32'({ct_out[0].last, ct_out[0].data}),
            32'({(k == 8), 16'(16'h1000 + k - 1)}));
      nxt();
    end

    // table-driven vectors
    foreach (vt[i]) begin
      idle_all();
      set_in(vt[i].sel, vt[i].iv, vt[i].il, vt[i].id);
      set_ordy(vt[i].sel, vt[i].ordy);
      @(negedge clk);
      f = out_f(vt[i].sel);
      chk($sformatf("vec%0d_in_ready", i), 32'(irdy_f(vt[i].sel)), 32'(vt[i].exp_irdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(f.valid), 32'(vt[i].exp_ov));
      if (vt[i].exp_ov)
        chk($sformatf("vec%0d_head", i), 32'({f.last, f.data}), 32'(vt[i].exp_head));
      nxt();
    end

    // channel independence: ch0 stalled, ch1 streams
    acc0 = 0;
    for (int k = 0; k <= 16; k++) begin
      idle_all();
      set_ordy(0, 1'b0);
      if (k < 16) set_in(1, 1'b1, (k == 15), 16'(16'h2000 + k));
      if (acc0 < 6) set_in(0, 1'b1, 1'b0, 16'(16'h3000 + acc0));
      @(negedge clk);
      r0 = ct_in_rdy[0];
      if (k < 16) chk($sformatf("indep_in_ready1_%0d", k), 32'(ct_in_rdy[1]), 32'd1);
      chk($sformatf("indep_out_valid1_%0d", k), 32'(ct_out[1].valid), 32'(k != 0));
      if (k != 0)
        chk($sformatf("indep_head1_%0d", k), 32'({ct_out[1].last, ct_out[1].data}),
            32'({(k == 16), 16'(16'h2000 + k - 1)}));
      if (r0 && acc0 < 6) acc0++;
      nxt();
    end
    chk("indep_ch0_accepted", 32'(acc0), 32'd4);
    @(negedge clk);
    chk("indep_ch0_in_ready", 32'(ct_in_rdy[0]), 32'd0);
    chk("indep_ch0_head", 32'({ct_out[0].valid, ct_out[0].last, ct_out[0].data}),
        32'({1'b1, 1'b0, 16'h3000}));
    nxt();
    drain();

    // reset mid-packet: 2 of 3 flits buffered on every stream
    idle_all();
    ct_out_rdy = 2'b00;
    for (int j = 0; j < 2; j++) begin
      for (int s = 0; s < 4; s++) set_in(s, 1'b1, 1'b0, 16'(16'hE000 + s * 16 + j));
      nxt();
    end
    idle_all();
    ct_out_rdy = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ct_out_valid", 32'({ct_out[1].valid, ct_out[0].valid}), 32'd0);
    chk("mid_rst_ct_in_ready", 32'(ct_in_rdy), 32'd0);
    nxt();
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    chk("after_rst_ct_out_valid", 32'({ct_out[1].valid, ct_out[0].valid}), 32'd0);
    chk("after_rst_sf_out_valid", 32'({sf_out[1].valid, sf_out[0].valid}), 32'd0);
    chk("after_rst_sf_in_ready", 32'(sf_in_rdy), 32'd3);
    nxt();
    set_in(2, 1'b1, 1'b0, 16'hF000);
    @(negedge clk);
    chk("after_rst_hold0", 32'(sf_out[0].valid), 32'd0);
    nxt();
    set_in(2, 1'b1, 1'b1, 16'hF001);
    @(negedge clk);
    chk("after_rst_hold1", 32'(sf_out[0].valid), 32'd0);
    nxt();
    idle_all();
    @(negedge clk);
    chk("after_rst_release", 32'({sf_out[0].valid, sf_out[0].last, sf_out[0].data}),
        32'({1'b1, 1'b0, 16'hF000}));
    nxt();
    drain();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("final_idle_%0d", c),
          32'({ct_out[1].valid, ct_out[0].valid, sf_out[1].valid, sf_out[0].valid}), 32'd0);
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
